int_dispatch: RTL and testbench
===============================

INT_DISPATCH -- requirements
Module: int_dispatch

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all ports are listed below, clock and reset first.
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  dispatch can accept an instruction
- in_op  in  3  ADD=0, SUB=1, SHFTL=2, SHFTR=3, AND=4, OR=5, XOR=6, 7=illegal
- in_rd  in  4  destination register
- in_rs1  in  4  source register A
- in_rs2  in  4  source register B
- in_use_imm  in  1  B operand = in_imm instead of reg[in_rs2]
- in_imm  in  32  immediate
- alu_a  out  32  operand A to the integer ALU (registered)
- alu_b  out  32  operand B to the integer ALU (registered)
- alu_op  out  3  opcode to the integer ALU (registered)
- alu_y  in  32  combinational ALU result for alu_a/alu_b/alu_op
- wb_valid  out  1  writeback result valid
- wb_ready  in  1  writeback consumer ready
- wb_rd  out  4  writeback destination
- wb_data  out  32  writeback value
- err_illegal  out  1  sticky: op 7 received
- retired  out  16  count of completed writebacks
- dbg_addr  in  4  debug read address
- dbg_data  out  32  reg[dbg_addr], combinational

Function
REQ-002 SHALL hold 16 x 32-bit registers; reg[0] reads as 0 and writes to it are discarded; the wb_rd=0 writeback still occurs.
REQ-003 SHALL accept an instruction on the cycle in_valid && in_ready.
REQ-004 SHALL have 2 stages, EX and WB; an instruction accepted at cycle N presents alu_a/alu_b/alu_op with ex_valid at N+1.
- The REQ-004 instruction then shows wb_valid/wb_rd/wb_data = alu_y at N+2, absent stalls.
REQ-005 SHALL write reg[rd] <= alu_y on the same edge that loads the WB registers.
REQ-006 SHALL forward alu_y into an operand read when the source register equals the EX-stage rd, rd != 0, and EX is valid.
- Otherwise the operand SHALL read the register file, which already holds all older results.
REQ-007 SHALL source B from in_imm when in_use_imm=1, with no forwarding on B.
REQ-008 SHALL freeze the pipeline while wb_valid && !wb_ready (stall).
- During stall: in_ready=0, and EX, WB and regfile hold.
- alu_* SHALL stay stable, so alu_y stays stable.
REQ-009 SHALL drive in_ready = !stall.
REQ-010 SHALL accept an instruction with in_op=7, set err_illegal=1 (sticky), and drop it.
- A dropped op-7 instruction creates no EX bubble, no regfile write and no retired count.
REQ-011 SHALL clear wb_valid the cycle after a handshake (wb_valid && wb_ready) if EX was empty.
REQ-012 SHALL increment retired on each wb handshake, modulo 2^16 (0xFFFF -> 0x0000).
REQ-013 SHALL let back-to-back dependent instructions issue at 1 per cycle with no bubbles.

Reset
REQ-014 On rst_n=0 at a clock edge, SHALL drive in_ready=0 for that cycle.
- Also at reset: wb_valid=0, ex_valid=0, alu_a=alu_b=0, alu_op=0, wb_rd=0, wb_data=0.
- Also at reset: err_illegal=0, retired=0, all registers 0.
REQ-015 Reset mid-operation SHALL discard in-flight EX/WB instructions without writing the register file.
REQ-016 in_ready SHALL be 1 on the first cycle after rst_n returns to 1.

Verification
REQ-017 Imm load: ADD r1=r0+imm 5, then ADD r2=r0+imm 7 -> wb (1,5) at N+2, wb (2,7) at N+3, dbg r2=7.
REQ-018 Forwarding: ADD r1=r0+imm 3, then SHFTL r3=r1<<imm 4 next cycle -> alu_a=3 from forward; wb (3,0x30); retired=2.
REQ-019 Backpressure: wb_ready=0 for 3 cycles with 2 instructions in flight -> in_ready=0, alu_*/wb_* constant; order and values preserved on release.
REQ-020 Illegal: op=7 -> err_illegal=1 next cycle, stays 1; no wb_valid; retired unchanged.
- A legal instruction afterwards SHALL still execute.
REQ-021 r0 and wrap: ADD r0=r0+imm 9 -> wb_data=9 but dbg r0=0.
- Preload retired=0xFFFF (65535 ops), then one more op -> retired=0x0000.
REQ-022 Reset mid-flight: rst_n=0 while EX and WB are valid -> all outputs at reset values next cycle; dbg of the target registers reads 0.

Source files
------------

// File: rtl/int_dispatch_if.sv
// Instruction-in, ALU, writeback and debug signals of the integer dispatch block.
// The slave modport is the dispatch side; the master modport is the environment side.
interface int_dispatch_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_y;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_illegal;
    logic [15:0] retired;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        input  alu_y, wb_ready, dbg_addr,
        output in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data,
        output err_illegal, retired, dbg_data
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
        output alu_y, wb_ready, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data,
        input  err_illegal, retired, dbg_data
    );
endinterface

// File: rtl/int_dispatch.sv
// Two-stage (EX, WB) integer dispatch with a 16x32 register file, EX->operand
// forwarding, writeback backpressure, sticky illegal-op flag and retire counter.
module int_dispatch (
    input  logic           clk,
    input  logic           rst_n,
    int_dispatch_if.slave  bus
);
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    logic [31:0] r_regs [16];
    logic        r_ex_valid;
    logic [3:0]  r_ex_rd;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_op;
    logic        r_wb_valid;
    logic [3:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_err_illegal;
    logic [15:0] r_retired;

    logic        w_stall;
    logic        w_accept;
    logic        w_issue;
    logic        w_fwd_a;
    logic        w_fwd_b;
    logic [31:0] w_opnd_a;
    logic [31:0] w_opnd_b;

    assign w_stall  = r_wb_valid && !bus.wb_ready;
    assign bus.in_ready = rst_n && !w_stall;
    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_issue  = w_accept && (bus.in_op != OP_ILLEGAL);

    // Older results are already in the regfile; only the EX result needs a bypass.
    assign w_fwd_a  = r_ex_valid && (r_ex_rd != 4'd0) && (bus.in_rs1 == r_ex_rd);
    assign w_fwd_b  = r_ex_valid && (r_ex_rd != 4'd0) && (bus.in_rs2 == r_ex_rd);
    assign w_opnd_a = w_fwd_a ? bus.alu_y : r_regs[bus.in_rs1];
    assign w_opnd_b = bus.in_use_imm ? bus.in_imm :
                      (w_fwd_b ? bus.alu_y : r_regs[bus.in_rs2]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
        end else if (!w_stall) begin
            r_ex_valid <= w_issue;
            if (w_issue) begin
                r_ex_rd  <= bus.in_rd;
                r_alu_a  <= w_opnd_a;
                r_alu_b  <= w_opnd_b;
                r_alu_op <= bus.in_op;
            end
        end
    end

    // WB registers and the regfile load from alu_y on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else if (!w_stall) begin
            r_wb_valid <= r_ex_valid;
            if (r_ex_valid) begin
                r_wb_rd   <= r_ex_rd;
                r_wb_data <= bus.alu_y;
                if (r_ex_rd != 4'd0) r_regs[r_ex_rd] <= bus.alu_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_illegal <= 1'b0;
            r_retired     <= '0;
        end else begin
            if (w_accept && (bus.in_op == OP_ILLEGAL)) r_err_illegal <= 1'b1;
            if (r_wb_valid && bus.wb_ready) r_retired <= r_retired + 16'd1;
        end
    end

    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign bus.err_illegal = r_err_illegal;
    assign bus.retired     = r_retired;
    assign bus.dbg_data    = r_regs[bus.dbg_addr];
endmodule

// File: tb/tb_int_dispatch.sv
// Directed bench for int_dispatch: a vector table for the forwarding chain plus
// hand-written sequences for stall, illegal op, r0, retire wrap and mid-flight reset.
module tb_int_dispatch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int_dispatch_if bus ();

    int_dispatch u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference integer ALU feeding alu_y.
    always_comb begin
        case (bus.alu_op)
            3'd0:    bus.alu_y = bus.alu_a + bus.alu_b;
            3'd1:    bus.alu_y = bus.alu_a - bus.alu_b;
            3'd2:    bus.alu_y = bus.alu_a << bus.alu_b[4:0];
            3'd3:    bus.alu_y = bus.alu_a >> bus.alu_b[4:0];
            3'd4:    bus.alu_y = bus.alu_a & bus.alu_b;
            3'd5:    bus.alu_y = bus.alu_a | bus.alu_b;
            3'd6:    bus.alu_y = bus.alu_a ^ bus.alu_b;
            default: bus.alu_y = 32'd0;
        endcase
    end

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        use_imm;
        logic [31:0] imm;
        logic        exp_wb_valid;
        logic [3:0]  exp_wb_rd;
        logic [31:0] exp_wb_data;
        logic [31:0] exp_alu_a;
    } vec_t;

    vec_t vecs [12];
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_ret = 16'd0;
    logic [31:0] held_a, held_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic ui, input logic [31:0] imm);
        bus.in_valid   = v;
        bus.in_op      = op;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_use_imm = ui;
        bus.in_imm     = imm;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg(input string name, input logic [3:0] a, input logic [31:0] exp);
        bus.dbg_addr = a;
        #1;
        chk(name, bus.dbg_data, exp);
    endtask

    initial begin
        //        v  op  rd  rs1 rs2 imm?  imm        wbv rd  data       alu_a
        vecs[0]  = '{1, 0,  1,  0,  0,  1,   32'h5,     0,  0,  32'h0,     32'h0};
        vecs[1]  = '{1, 0,  2,  0,  0,  1,   32'h7,     0,  0,  32'h0,     32'h0};
        vecs[2]  = '{1, 2,  3,  2,  0,  1,   32'h4,     1,  1,  32'h5,     32'h0};
        vecs[3]  = '{1, 0,  4,  3,  1,  0,   32'h0,     1,  2,  32'h7,     32'h7};
        vecs[4]  = '{1, 1,  5,  4,  2,  0,   32'h0,     1,  3,  32'h70,    32'h70};
        vecs[5]  = '{1, 6,  6,  5,  0,  1,   32'hFF,    1,  4,  32'h75,    32'h75};
        vecs[6]  = '{1, 4,  7,  6,  4,  0,   32'h0,     1,  5,  32'h6E,    32'h6E};
        vecs[7]  = '{1, 5,  8,  7,  0,  1,   32'h100,   1,  6,  32'h91,    32'h91};
        vecs[8]  = '{1, 3,  9,  8,  0,  1,   32'h4,     1,  7,  32'h11,    32'h11};
        vecs[9]  = '{0, 0,  0,  0,  0,  0,   32'h0,     1,  8,  32'h111,   32'h111};
        vecs[10] = '{0, 0,  0,  0,  0,  0,   32'h0,     1,  9,  32'h11,    32'h111};
        vecs[11] = '{0, 0,  0,  0,  0,  0,   32'h0,     0,  9,  32'h11,    32'h111};

        idle();
        bus.wb_ready = 1'b1;
        bus.dbg_addr = 4'd0;
        next(); next();
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("reset alu_a", bus.alu_a, 32'd0);
        chk("reset retired", {16'd0, bus.retired}, 32'd0);
        chk("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        next();

        // Forwarding chain, one instruction per cycle.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].use_imm, vecs[i].imm);
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            chk($sformatf("vec%0d wb_valid", i), {31'd0, bus.wb_valid}, {31'd0, vecs[i].exp_wb_valid});
            if (vecs[i].exp_wb_valid) begin
                chk($sformatf("vec%0d wb_rd", i), {28'd0, bus.wb_rd}, {28'd0, vecs[i].exp_wb_rd});
                chk($sformatf("vec%0d wb_data", i), bus.wb_data, vecs[i].exp_wb_data);
            end
            chk($sformatf("vec%0d alu_a", i), bus.alu_a, vecs[i].exp_alu_a);
            next();
        end
        exp_ret = 16'd9;
        chk("chain retired", {16'd0, bus.retired}, {16'd0, exp_ret});
        dbg("dbg r2", 4'd2, 32'h7);
        dbg("dbg r9", 4'd9, 32'h11);

        // Backpressure with two instructions in flight.
        bus.wb_ready = 1'b0;
        drive(1'b1, 3'd0, 4'd10, 4'd0, 4'd0, 1'b1, 32'hA);
        next();
        drive(1'b1, 3'd0, 4'd11, 4'd10, 4'd0, 1'b1, 32'h1);
        next();
        idle();
        held_a = bus.alu_a;
        held_b = bus.alu_b;
        chk("stall alu_a fwd", held_a, 32'hA);
        chk("stall alu_b", held_b, 32'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d in_ready", c), {31'd0, bus.in_ready}, 32'd0);
            chk($sformatf("stall%0d wb_rd", c), {28'd0, bus.wb_rd}, 32'd10);
            chk($sformatf("stall%0d wb_data", c), bus.wb_data, 32'hA);
            chk($sformatf("stall%0d alu_a", c), bus.alu_a, held_a);
            chk($sformatf("stall%0d alu_b", c), bus.alu_b, held_b);
            next();
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        chk("release wb0 rd", {28'd0, bus.wb_rd}, 32'd10);
        next();
        @(negedge clk);
        chk("release wb1 valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("release wb1 rd", {28'd0, bus.wb_rd}, 32'd11);
        chk("release wb1 data", bus.wb_data, 32'hB);
        next();
        @(negedge clk);
        chk("release drained", {31'd0, bus.wb_valid}, 32'd0);
        exp_ret += 16'd2;
        chk("release retired", {16'd0, bus.retired}, {16'd0, exp_ret});
        next();

        // Illegal op is flagged and dropped.
        drive(1'b1, 3'd7, 4'd12, 4'd1, 4'd1, 1'b0, 32'd0);
        #1;
        chk("illegal accepted", {31'd0, bus.in_ready}, 32'd1);
        next();
        idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("illegal%0d err", c), {31'd0, bus.err_illegal}, 32'd1);
            chk($sformatf("illegal%0d wb_valid", c), {31'd0, bus.wb_valid}, 32'd0);
            next();
        end
        chk("illegal retired", {16'd0, bus.retired}, {16'd0, exp_ret});
        dbg("illegal r12", 4'd12, 32'd0);
        drive(1'b1, 3'd0, 4'd12, 4'd0, 4'd0, 1'b1, 32'h42);
        next();
        idle();
        next();
        @(negedge clk);
        chk("after illegal wb_rd", {28'd0, bus.wb_rd}, 32'd12);
        chk("after illegal wb_data", bus.wb_data, 32'h42);
        chk("after illegal err", {31'd0, bus.err_illegal}, 32'd1);
        next();
        exp_ret += 16'd1;

        // Write to r0 still retires but leaves r0 at zero.
        drive(1'b1, 3'd0, 4'd0, 4'd0, 4'd0, 1'b1, 32'h9);
        next();
        idle();
        next();
        @(negedge clk);
        chk("r0 wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("r0 wb_rd", {28'd0, bus.wb_rd}, 32'd0);
        chk("r0 wb_data", bus.wb_data, 32'h9);
        next();
        next();
        exp_ret += 16'd1;
        dbg("dbg r0", 4'd0, 32'd0);
        chk("r0 retired", {16'd0, bus.retired}, {16'd0, exp_ret});

        // Retire counter wrap.
        drive(1'b1, 3'd0, 4'd0, 4'd0, 4'd0, 1'b1, 32'h1);
        for (int n = 0; n < int'(16'hFFFF - exp_ret); n++) next();
        idle();
        next(); next(); next();
        chk("retired full", {16'd0, bus.retired}, 32'h0000FFFF);
        drive(1'b1, 3'd0, 4'd0, 4'd0, 4'd0, 1'b1, 32'h1);
        next();
        idle();
        next(); next(); next();
        chk("retired wrap", {16'd0, bus.retired}, 32'h00000000);

        // Reset while EX and WB both hold instructions.
        drive(1'b1, 3'd0, 4'd13, 4'd0, 4'd0, 1'b1, 32'h1);
        next();
        drive(1'b1, 3'd0, 4'd14, 4'd0, 4'd0, 1'b1, 32'h2);
        next();
        idle();
        chk("pre-reset wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        next();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst wb_rd", {28'd0, bus.wb_rd}, 32'd0);
        chk("rst wb_data", bus.wb_data, 32'd0);
        chk("rst alu_a", bus.alu_a, 32'd0);
        chk("rst alu_b", bus.alu_b, 32'd0);
        chk("rst alu_op", {29'd0, bus.alu_op}, 32'd0);
        chk("rst err", {31'd0, bus.err_illegal}, 32'd0);
        chk("rst retired", {16'd0, bus.retired}, 32'd0);
        chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        dbg("rst r13", 4'd13, 32'd0);
        dbg("rst r14", 4'd14, 32'd0);
        dbg("rst r2", 4'd2, 32'd0);
        next();
        @(negedge clk);
        chk("rst drained wb_valid", {31'd0, bus.wb_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
